// File: rtl/crc16_pkg.sv
// Shared constants, status-word layout and the single-bit CRC step for the crc16 engine.
// The parallel fold is selected by the CRC16_PARALLEL_EN macro in crc16_engine.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY  = 16'h1021;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_CHECK = 16'h29B1;

  localparam int STAT_READY   = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_OVR     = 2;
  localparam int STAT_CNT_LSB = 16;

  localparam logic [3:0] CRC16_BITS_PER_BYTE = 4'd8;

  typedef enum logic {
    CRC_IDLE  = 1'b0,
    CRC_SHIFT = 1'b1
  } crc_state_e;

  // One MSB-first shift of the CRC register with the incoming data bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        data_bit,
                                             input logic [15:0] poly);
    crc16_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ data_bit) == 1'b1) ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_bit_step.sv
// Combinational single-bit CRC-16 step; chained 8 times for the parallel byte fold.
module crc16_bit_step
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic [15:0] crc_in,
  input  logic        data_bit,
  output logic [15:0] crc_out
);

  // Feedback shift against the generator polynomial.
  always_comb begin
    crc_out = crc16_step(crc_in, data_bit, POLY);
  end

endmodule

// File: rtl/crc16_engine.sv
// CRC-16/CCITT-FALSE engine fed one byte per crc_feed pulse, bit-serial by default.
// Define CRC16_PARALLEL_EN to fold each byte in a single clock instead.
module crc16_engine
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY,
  parameter logic [15:0] INIT = CRC16_INIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crc_init,
  input  logic        crc_feed,
  input  logic [7:0]  crc_byte,
  output logic        crc_busy,
  output logic [15:0] crc_value,
  output logic [31:0] stat_out
);

  logic [15:0] crc_r;
  logic [15:0] byte_count_r;
  logic        overrun_s;
  logic        busy_s;
  logic [31:0] stat_s;

`ifdef CRC16_PARALLEL_EN

  logic [15:0] chain_s [0:8];

  // An init in the same cycle as a feed folds the byte against INIT.
  assign chain_s[0] = crc_init ? INIT : crc_r;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_fold
      crc16_bit_step #(.POLY(POLY)) u_step (
        .crc_in   (chain_s[gi]),
        .data_bit (crc_byte[7 - gi]),
        .crc_out  (chain_s[gi + 1])
      );
    end
  endgenerate

  // CRC register and byte counter for the single-cycle fold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_r        <= INIT;
      byte_count_r <= 16'd0;
    end else if (crc_feed) begin
      crc_r        <= chain_s[8];
      byte_count_r <= crc_init ? 16'd1 : (byte_count_r + 16'd1);
    end else if (crc_init) begin
      crc_r        <= INIT;
      byte_count_r <= 16'd0;
    end else begin
      crc_r        <= crc_r;
      byte_count_r <= byte_count_r;
    end
  end

  assign overrun_s = 1'b0;
  assign busy_s    = crc_feed;

`else

  logic [7:0]  shift_r;
  logic [3:0]  bit_cnt_r;
  logic        overrun_r;
  logic [15:0] step_s;
  crc_state_e  state_s;

  crc16_bit_step #(.POLY(POLY)) u_step (
    .crc_in   (crc_r),
    .data_bit (shift_r[7]),
    .crc_out  (step_s)
  );

  // The engine is idle exactly when no bits of the current byte remain.
  always_comb begin
    if (bit_cnt_r == 4'd0) begin
      state_s = CRC_IDLE;
    end else begin
      state_s = CRC_SHIFT;
    end
  end

  // Byte acceptance, bit-serial shifting, init/abort and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_r        <= INIT;
      shift_r      <= 8'h00;
      bit_cnt_r    <= 4'd0;
      byte_count_r <= 16'd0;
      overrun_r    <= 1'b0;
    end else if (crc_init) begin
      crc_r     <= INIT;
      overrun_r <= 1'b0;
      if (crc_feed) begin
        shift_r      <= crc_byte;
        bit_cnt_r    <= CRC16_BITS_PER_BYTE;
        byte_count_r <= 16'd1;
      end else begin
        shift_r      <= 8'h00;
        bit_cnt_r    <= 4'd0;
        byte_count_r <= 16'd0;
      end
    end else begin
      case (state_s)
        CRC_IDLE: begin
          if (crc_feed) begin
            shift_r      <= crc_byte;
            bit_cnt_r    <= CRC16_BITS_PER_BYTE;
            byte_count_r <= byte_count_r + 16'd1;
          end
        end
        CRC_SHIFT: begin
          crc_r     <= step_s;
          shift_r   <= {shift_r[6:0], 1'b0};
          bit_cnt_r <= bit_cnt_r - 4'd1;
          // A byte offered mid-shift is dropped and flagged.
          if (crc_feed) begin
            overrun_r <= 1'b1;
          end
        end
        default: begin
          bit_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign overrun_s = overrun_r;
  assign busy_s    = crc_feed | (bit_cnt_r != 4'd0);

`endif

  // Read-only status word for the CPU bus.
  always_comb begin
    stat_s                        = 32'h0000_0000;
    stat_s[STAT_READY]            = ~busy_s;
    stat_s[STAT_BUSY]             = busy_s;
    stat_s[STAT_OVR]              = overrun_s;
    stat_s[STAT_CNT_LSB +: 16]    = byte_count_r;
  end

  assign crc_busy  = busy_s;
  assign crc_value = crc_r;
  assign stat_out  = stat_s;

endmodule
